// File: rtl/clk_en_sched_pkg.sv
// Shared defaults, field types and config FSM encoding for the clock-enable scheduler.
package clk_en_sched_pkg;

    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned CH_W_DEF   = $clog2(NUM_CH_DEF);
    localparam int unsigned EXP_W_DEF  = $clog2(CNT_W_DEF);

    typedef logic [CH_W_DEF-1:0]  ch_t;
    typedef logic [EXP_W_DEF-1:0] exp_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/clk_en_prescaler.sv
// Free-running prescaler shared by all clock-enable channels; freezes while hold is high.
module clk_en_prescaler #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             cin,
    input  logic             reset,
    input  logic             hold,
    output logic [CNT_W-1:0] cnt
);

    // Wrap-around counter, synchronous active-low clear.
    always_ff @(posedge cin) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: per-channel one-cycle strobes at 2^(e+1) cycle periods,
// derived from one shared prescaler, with glitch-free reconfiguration at strike
// boundaries. Optional freeze input enabled by CLK_EN_SCHED_HOLD_EN.
module clk_en_sched
    import clk_en_sched_pkg::*;
#(
    parameter  int unsigned NUM_CH = NUM_CH_DEF,
    parameter  int unsigned CNT_W  = CNT_W_DEF,
    localparam int unsigned CH_W   = $clog2(NUM_CH),
    localparam int unsigned EXP_W  = $clog2(CNT_W)
) (
`ifdef CLK_EN_SCHED_HOLD_EN
    input  logic              hold,
`endif
    input  logic              cin,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [EXP_W-1:0]  cfg_exp,
    input  logic              cfg_on,
    output logic [NUM_CH-1:0] en_o,
    output logic [NUM_CH-1:0] active_o,
    output logic              busy_o
);

    logic             hold_c;
    logic [CNT_W-1:0] cnt;

`ifdef CLK_EN_SCHED_HOLD_EN
    assign hold_c = hold;
`else
    assign hold_c = 1'b0;
`endif

    clk_en_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .cin   (cin),
        .reset (reset),
        .hold  (hold_c),
        .cnt   (cnt)
    );

    cfg_state_t        state_q, state_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    logic [EXP_W-1:0]  pend_exp_q, pend_exp_d;
    logic              pend_on_q, pend_on_d;
    logic [NUM_CH-1:0] active_q, active_d;
    logic [EXP_W-1:0]  exp_q [NUM_CH];
    logic [EXP_W-1:0]  exp_d [NUM_CH];
    logic [NUM_CH-1:0] strike_c;
    logic [NUM_CH-1:0] en_q;

    // True when the low e+1 bits of the prescaler are all ones.
    function automatic logic period_hit(input logic [CNT_W-1:0] c, input logic [EXP_W-1:0] e);
        logic [CNT_W:0] mask;
        mask = ((CNT_W+1)'(1) << (32'(e) + 32'd1)) - (CNT_W+1)'(1);
        return (({1'b0, c} & mask) == mask);
    endfunction

    // Per-channel strike compare against the shared prescaler phase.
    always_comb begin
        strike_c = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            strike_c[k] = active_q[k] && period_hit(cnt, exp_q[k]);
        end
    end

    // Config FSM next state; an active channel changes only on its own strike so
    // the strike in progress still uses the old exponent and is never truncated.
    always_comb begin
        state_d    = state_q;
        pend_ch_d  = pend_ch_q;
        pend_exp_d = pend_exp_q;
        pend_on_d  = pend_on_q;
        active_d   = active_q;
        for (int k = 0; k < NUM_CH; k++) begin
            exp_d[k] = exp_q[k];
        end
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    pend_ch_d  = cfg_ch;
                    pend_exp_d = cfg_exp;
                    pend_on_d  = cfg_on;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (!hold_c && (!active_q[pend_ch_q] || strike_c[pend_ch_q])) begin
                    active_d[pend_ch_q] = pend_on_q;
                    exp_d[pend_ch_q]    = pend_exp_q;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, settings and strobe registers.
    always_ff @(posedge cin) begin
        if (!reset) begin
            state_q    <= IDLE;
            pend_ch_q  <= '0;
            pend_exp_q <= '0;
            pend_on_q  <= 1'b0;
            active_q   <= '0;
            en_q       <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                exp_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pend_ch_q  <= pend_ch_d;
            pend_exp_q <= pend_exp_d;
            pend_on_q  <= pend_on_d;
            active_q   <= active_d;
            en_q       <= hold_c ? '0 : strike_c;
            for (int k = 0; k < NUM_CH; k++) begin
                exp_q[k] <= exp_d[k];
            end
        end
    end

    assign en_o      = en_q;
    assign active_o  = active_q;
    assign cfg_ready = (state_q == IDLE);
    assign busy_o    = (state_q == PEND);

endmodule

// File: tb/tb_clk_en_sched.sv
// Scoreboard bench for clk_en_sched: stimulus queues the cycle of every expected
// strobe per channel; a monitor pops and compares whenever a strobe appears.
// cyc counts posedges since reset release, so it equals the prescaler value mod 256
// whenever hold is not used.
module tb_clk_en_sched;

    localparam int unsigned NUM_CH = 4;

    logic       cin;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [2:0] cfg_exp;
    logic       cfg_on;
    logic [3:0] en_o;
    logic [3:0] active_o;
    logic       busy_o;
`ifdef CLK_EN_SCHED_HOLD_EN
    logic       hold;
`endif

    int cyc;
    int tests;
    int fails;
    int expq [NUM_CH][$];

    clk_en_sched dut (
`ifdef CLK_EN_SCHED_HOLD_EN
        .hold      (hold),
`endif
        .cin       (cin),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_exp   (cfg_exp),
        .cfg_on    (cfg_on),
        .en_o      (en_o),
        .active_o  (active_o),
        .busy_o    (busy_o)
    );

    initial begin
        cin = 1'b0;
        forever #5 cin = ~cin;
    end

    always @(posedge cin) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge cin);
            #1;
        end
    endtask

    task automatic push_range(input int ch, input int first, input int last, input int step);
        for (int c = first; c <= last; c += step) expq[ch].push_back(c);
    endtask

    // Present a request, wait (bounded) for cfg_ready, drop valid after acceptance.
    task automatic cfg(input int ch, input int e, input bit on);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_exp   = 3'(e);
        cfg_on    = on;
        while (!cfg_ready && n < 1000) begin
            @(posedge cin);
            #1;
            n++;
        end
        if (n >= 1000) check("cfg_ready_timeout", n, 0);
        @(posedge cin);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic stimulus();
        reset = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch = '0;
        cfg_exp = '0;
        cfg_on = 1'b0;
`ifdef CLK_EN_SCHED_HOLD_EN
        hold = 1'b0;
`endif
        repeat (3) @(posedge cin);
        #1;
        check("reset_en_o", int'(en_o), 0);
        check("reset_active_o", int'(active_o), 0);
        check("reset_cfg_ready", int'(cfg_ready), 1);
        check("reset_busy_o", int'(busy_o), 0);
        reset = 1'b1;

        // ch0 exp=0 on a disabled channel: applies in the single PEND cycle
        goto(10);
        push_range(0, 14, 24, 2);
        cfg(0, 0, 1'b1);
        check("a_busy_pend", int'(busy_o), 1);
        goto(12);
        check("a_busy_done", int'(busy_o), 0);
        check("a_active", int'(active_o), 1);

        // ch0 exp 0->2 waits for ch0 strike; a second request during PEND is dropped
        goto(21);
        push_range(0, 32, 552, 8);
        cfg(0, 2, 1'b1);
        check("b_ready_pend", int'(cfg_ready), 0);
        check("b_busy_pend", int'(busy_o), 1);
        cfg_valid = 1'b1;
        cfg_ch = 2'd1;
        cfg_exp = 3'd0;
        cfg_on = 1'b1;
        goto(23);
        check("b_busy_second", int'(busy_o), 1);
        goto(24);
        check("b_busy_done", int'(busy_o), 0);
        check("b_ready_done", int'(cfg_ready), 1);
        check("b_active_ignored", int'(active_o), 1);
        cfg_valid = 1'b0;

        // ch1 exp=7: one pulse per 256 cycles, after cnt=255
        goto(30);
        expq[1].push_back(256);
        expq[1].push_back(512);
        expq[1].push_back(768);
        cfg(1, 7, 1'b1);

        // ch2 exp=3 enabled, then disabled at its strike boundary
        goto(520);
        push_range(2, 528, 544, 16);
        cfg(2, 3, 1'b1);
        check("d_busy_enable", int'(busy_o), 1);
        goto(522);
        check("d_active_on", int'(active_o), 7);
        goto(530);
        cfg(2, 3, 1'b0);
        check("d_busy_disable", int'(busy_o), 1);
        goto(543);
        check("d_busy_wait", int'(busy_o), 1);
        check("d_active_wait", int'(active_o), 7);
        goto(544);
        check("d_busy_done", int'(busy_o), 0);
        check("d_active_off", int'(active_o), 3);

        // ch0 exp=1, ch1 exp=0: ch1 change lands on the cnt wrap strike
        goto(550);
        push_range(0, 556, 784, 4);
        cfg(0, 1, 1'b1);
        goto(560);
        push_range(1, 770, 784, 2);
        cfg(1, 0, 1'b1);
        check("e_busy_long", int'(busy_o), 1);
        goto(767);
        check("e_busy_wrap", int'(busy_o), 1);
        goto(768);
        check("e_busy_done", int'(busy_o), 0);

        // reset in the middle of a pending request
        goto(784);
        cfg(0, 0, 1'b1);
        check("f_busy_pend", int'(busy_o), 1);
        reset = 1'b0;
        @(posedge cin);
        #1;
        check("f_active_rst", int'(active_o), 0);
        check("f_busy_rst", int'(busy_o), 0);
        check("f_ready_rst", int'(cfg_ready), 1);
        check("f_en_rst", int'(en_o), 0);
        @(posedge cin);
        #1;
        reset = 1'b1;

`ifdef CLK_EN_SCHED_HOLD_EN
        // hold for 10 cycles: strobes stop, prescaler resumes from the frozen value
        goto(10);
        expq[0].push_back(16);
        expq[0].push_back(20);
        expq[0].push_back(24);
        expq[0].push_back(38);
        expq[0].push_back(42);
        expq[0].push_back(46);
        cfg(0, 1, 1'b1);
        goto(25);
        hold = 1'b1;
        goto(35);
        hold = 1'b0;
        goto(48);
`else
        goto(30);
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        fork
            forever begin
                @(negedge cin);
                for (int k = 0; k < NUM_CH; k++) begin
                    if (en_o[k] === 1'b1) begin
                        if (expq[k].size() == 0)
                            check($sformatf("en_o[%0d]_unexpected", k), cyc, -1);
                        else
                            check($sformatf("en_o[%0d]_pulse", k), cyc, expq[k].pop_front());
                    end
                end
            end
            stimulus();
            begin
                #100000;
                check("global_timeout", 1, 0);
            end
        join_any
        disable fork;
        for (int k = 0; k < NUM_CH; k++)
            check($sformatf("missing_pulses_ch%0d", k), expq[k].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_en_sched.md
CLK_EN_SCHED -- requirements
Module: clk_en_sched

Interface
REQ-001 Parameter NUM_CH, default 4, number of clock-enable consumers (CPU, video, audio, timers).
REQ-002 Parameter CNT_W, default 8, prescaler width; divide exponents 0..CNT_W-1 give divide-by-2..divide-by-2^CNT_W.
REQ-003 cin  input  1  sole clock; every flop updates on posedge cin only.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 cfg_valid  input  1  configuration request.
REQ-006 cfg_ready  output  1  request can be accepted this cycle.
REQ-007 cfg_ch  input  $clog2(NUM_CH)  target channel.
REQ-008 cfg_exp  input  $clog2(CNT_W)  divide exponent e; period is 2^(e+1) cycles.
REQ-009 cfg_on  input  1  1 = channel enabled, 0 = channel disabled.
REQ-010 en_o  output  NUM_CH  one-cycle clock-enable strobes, one bit per channel.
REQ-011 active_o  output  NUM_CH  currently applied enable mask.
REQ-012 busy_o  output  1  a configuration is pending.
REQ-013 hold  input  1  freeze request; present only with CLK_EN_SCHED_HOLD_EN.

Function
REQ-014 Free-running CNT_W-bit prescaler cnt increments by 1 each cycle; wraps from 2^CNT_W-1 to 0.
REQ-015 Per-channel strike = active[k] and cnt[e_k:0] all ones; en_o[k] registered, high in cycle N+1 for a strike in cycle N, otherwise low.
REQ-016 Strobes are exactly one cycle wide; no generated clocks; all consumers use cin plus en_o.
REQ-017 Config FSM states IDLE and PEND; cfg_ready = (state==IDLE); busy_o = (state==PEND).
REQ-018 IDLE: cfg_valid high -> latch ch/exp/on into pending registers, go to PEND.
REQ-019 PEND, target channel active: apply pending exp/on in the cycle of that channel's next strike (the strike itself uses the old exponent), return to IDLE.
REQ-020 PEND, target channel inactive: apply in the first PEND cycle, return to IDLE.
REQ-021 Applied settings take effect for strikes from the cycle after the apply; the new period phase is taken from the shared cnt, so no partial first period is shorter than the new period's remaining count.
REQ-022 cfg_valid while cfg_ready low is ignored; the requester holds the request until cfg_ready is high.
REQ-023 Simultaneous strikes on several channels all pulse in the same cycle; no arbitration between strobes.
REQ-024 Apply coinciding with cnt wrap: the strike at cnt=2^CNT_W-1 is produced first, then the new setting applies.
REQ-025 A channel is disabled at its strike boundary, so no strobe is truncated.

Reset
REQ-026 reset low at posedge cin: cnt=0, active=0, all exponents 0, en_o=0, state IDLE, pending registers cleared.
REQ-027 Reset outputs while reset is low: cfg_ready=1, busy_o=0, active_o=0.
REQ-028 Reset in PEND discards the pending request; reset has priority over hold and cfg_valid.

Configuration
REQ-029 Feature macro: CLK_EN_SCHED_HOLD_EN.
REQ-030 With the macro defined: while hold is high, cnt freezes, en_o is forced to 0, and PEND does not apply; the FSM still accepts in IDLE. On release, counting resumes from the frozen value.
REQ-031 With the macro undefined: the hold port does not exist and the scheduler behaves as if hold were tied 0.

Structure
REQ-032 Package clk_en_sched_pkg holds NUM_CH and CNT_W defaults, typedef exp_t, typedef ch_t, and enum cfg_state_t {IDLE, PEND}.
REQ-033 One sub-module, clk_en_prescaler: cnt register with hold gating. The strike compare, FSM and registers stay in clk_en_sched.

Verification
REQ-034 Reset, then configure ch0 exp=0 on -> en_o[0] pulses every 2 cycles, 1 cycle wide; other bits remain 0.
REQ-035 ch1 exp=7 on -> exactly one en_o[1] pulse per 256 cycles; pulse follows the cnt=255 cycle.
REQ-036 ch0 exp=0 active, request exp=2 -> busy_o high for 1-2 cycles; next pulses are 8 cycles apart; cfg_ready low while PEND; a second cfg_valid during PEND is ignored.
REQ-037 Request on a disabled channel -> applies 1 cycle after accept; disabling an active exp=3 channel -> its last full pulse is still emitted.
REQ-038 ch0 exp=1 and ch1 exp=0 -> both pulse in the same cycle every 4 cycles; reset asserted mid-PEND -> active_o=0 and busy_o=0 next cycle.
REQ-039 With CLK_EN_SCHED_HOLD_EN: hold for 10 cycles -> no strobes and cnt unchanged; after release, pulse spacing resumes with the same phase.
